// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one RAM data port between the core LSU (C)
// and a DMA/loader master (D), round-robin with a bounded DMA lock.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   c_req/we/rtype/wtype/addr/wdata -> c_gnt, c_rvalid   core side
//   d_req/we/rtype/wtype/addr/wdata, d_lock -> d_gnt, d_rvalid  DMA side
//   rdata                   shared read-return bus (= ram_rdata)
//   ram_ren/wen/rtype/wtype/addr/wdata -> RAM command, ram_rdata <- RAM
module ram_port_arbiter #(
   parameter int ADDR_W    = 64,
   parameter int DATA_W    = 64,
   parameter int BURST_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              c_req,
   input  logic              c_we,
   input  logic [2:0]        c_rtype,
   input  logic [1:0]        c_wtype,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [DATA_W-1:0] c_wdata,
   output logic              c_gnt,
   output logic              c_rvalid,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [2:0]        d_rtype,
   input  logic [1:0]        d_wtype,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   input  logic              d_lock,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic              ram_ren,
   output logic              ram_wen,
   output logic [2:0]        ram_rtype,
   output logic [1:0]        ram_wtype,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   typedef enum logic {
      ST_RR    = 1'b0,
      ST_DLOCK = 1'b1
   } st_t;

   localparam logic [3:0] LP_MAX = 4'(BURST_MAX);

   st_t        r_st;
   logic       r_last;
   logic [3:0] r_cnt;
   logic       r_rv_c;
   logic       r_rv_d;

   logic       w_c_sel;
   logic       w_d_sel;
   logic       w_c_gnt;
   logic       w_d_gnt;
   logic [3:0] w_cnt_inc;
   logic       w_cap;
   logic       w_exit;

   // Requester selection from requests and registered state only.
   always_comb begin
      w_c_sel = 1'b0;
      w_d_sel = 1'b0;
      case (r_st)
         ST_RR: begin
            if (c_req && d_req) begin
               // last=1 means DMA went last, so the core wins now
               w_c_sel = r_last;
               w_d_sel = ~r_last;
            end else begin
               w_c_sel = c_req;
               w_d_sel = d_req;
            end
         end
         ST_DLOCK: begin
            w_d_sel = d_req;
         end
         default: begin
            w_c_sel = 1'b0;
            w_d_sel = 1'b0;
         end
      endcase
   end

   // Grants are forced low while reset is asserted so every output
   // drops immediately on an asynchronous reset.
   assign w_c_gnt = w_c_sel & rst_n;
   assign w_d_gnt = w_d_sel & rst_n;

   assign w_cnt_inc = r_cnt + 4'd1;
   assign w_cap     = w_d_gnt && (w_cnt_inc == LP_MAX);
   // A released lock and a burst cap in the same cycle give one exit.
   assign w_exit    = ~d_lock | w_cap;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_st   <= ST_RR;
         r_last <= 1'b1;
         r_cnt  <= 4'd0;
         r_rv_c <= 1'b0;
         r_rv_d <= 1'b0;
      end else begin
         r_rv_c <= w_c_gnt & ~c_we;
         r_rv_d <= w_d_gnt & ~d_we;
         case (r_st)
            ST_RR: begin
               if (w_c_gnt) begin
                  r_last <= 1'b0;
               end
               if (w_d_gnt) begin
                  r_last <= 1'b1;
                  if (d_lock) begin
                     r_st  <= ST_DLOCK;
                     r_cnt <= 4'd1;
                  end
               end
            end
            ST_DLOCK: begin
               if (w_d_gnt) begin
                  r_cnt <= w_cnt_inc;
               end
               if (w_exit) begin
                  r_st   <= ST_RR;
                  r_last <= 1'b1;
               end
            end
            default: begin
               r_st <= ST_RR;
            end
         endcase
      end
   end

   // RAM command mux: zeros when nobody is granted.
   always_comb begin
      ram_ren   = 1'b0;
      ram_wen   = 1'b0;
      ram_rtype = 3'd0;
      ram_wtype = 2'd0;
      ram_addr  = '0;
      ram_wdata = '0;
      if (w_c_gnt) begin
         ram_ren   = ~c_we;
         ram_wen   = c_we;
         ram_rtype = c_rtype;
         ram_wtype = c_wtype;
         ram_addr  = c_addr;
         ram_wdata = c_wdata;
      end else if (w_d_gnt) begin
         ram_ren   = ~d_we;
         ram_wen   = d_we;
         ram_rtype = d_rtype;
         ram_wtype = d_wtype;
         ram_addr  = d_addr;
         ram_wdata = d_wdata;
      end
   end

   assign c_gnt    = w_c_gnt;
   assign d_gnt    = w_d_gnt;
   assign c_rvalid = r_rv_c;
   assign d_rvalid = r_rv_d;
   assign rdata    = ram_rdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed stimulus with literal expectations plus
// a per-cycle compare against an ownership-level model of the arbiter.
module tb_ram_port_arbiter;

   localparam int AW = 64;
   localparam int DW = 64;
   localparam int BM = 4;
   localparam logic [63:0] PAT = 64'hA5A5_A5A5_A5A5_A5A5;

   logic          clk;
   logic          rst_n;
   logic          c_req, c_we;
   logic [2:0]    c_rtype;
   logic [1:0]    c_wtype;
   logic [AW-1:0] c_addr;
   logic [DW-1:0] c_wdata;
   logic          c_gnt, c_rvalid;
   logic          d_req, d_we, d_lock;
   logic [2:0]    d_rtype;
   logic [1:0]    d_wtype;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic          d_gnt, d_rvalid;
   logic [DW-1:0] rdata;
   logic          ram_ren, ram_wen;
   logic [2:0]    ram_rtype;
   logic [1:0]    ram_wtype;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata;

   int total = 0;
   int bad   = 0;

   ram_port_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .BURST_MAX(BM)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .c_req(c_req), .c_we(c_we), .c_rtype(c_rtype),
      .c_wtype(c_wtype), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_gnt(c_gnt), .c_rvalid(c_rvalid),
      .d_req(d_req), .d_we(d_we), .d_rtype(d_rtype),
      .d_wtype(d_wtype), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_lock(d_lock), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
      .rdata(rdata), .ram_ren(ram_ren), .ram_wen(ram_wen),
      .ram_rtype(ram_rtype), .ram_wtype(ram_wtype),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Simple RAM: read data is a fixed function of the address.
   initial ram_rdata = '0;
   always @(posedge clk) begin
      if (ram_ren) ram_rdata <= ram_addr ^ PAT;
   end

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- model ----------------
   // Ownership view: locked burst with a beat count, otherwise the
   // requester that did not go last is preferred.
   logic          m_locked;
   int            m_beats;
   logic          m_pref_c;
   logic          m_rv_c, m_rv_d;
   logic [AW-1:0] m_rd_addr;
   logic          e_c, e_d;

   always_comb begin
      e_c = 1'b0;
      e_d = 1'b0;
      if (rst_n) begin
         if (m_locked) begin
            e_d = d_req;
         end else if (c_req && d_req) begin
            e_c = m_pref_c;
            e_d = !m_pref_c;
         end else begin
            e_c = c_req;
            e_d = d_req;
         end
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_locked  <= 1'b0;
         m_beats   <= 0;
         m_pref_c  <= 1'b1;
         m_rv_c    <= 1'b0;
         m_rv_d    <= 1'b0;
         m_rd_addr <= '0;
      end else begin
         m_rv_c <= e_c && !c_we;
         m_rv_d <= e_d && !d_we;
         if (e_c && !c_we) m_rd_addr <= c_addr;
         if (e_d && !d_we) m_rd_addr <= d_addr;
         if (e_c) m_pref_c <= 1'b0;
         if (e_d) m_pref_c <= 1'b1;
         if (!m_locked) begin
            if (e_d && d_lock) begin
               m_locked <= 1'b1;
               m_beats  <= 1;
            end
         end else begin
            if (e_d) m_beats <= m_beats + 1;
            if (!d_lock || (e_d && m_beats + 1 >= BM))
               m_locked <= 1'b0;
         end
      end
   end

   // Per-cycle compare of every output against the model.
   always @(negedge clk) begin
      logic          x_ren, x_wen;
      logic [2:0]    x_rt;
      logic [1:0]    x_wt;
      logic [AW-1:0] x_a;
      logic [DW-1:0] x_wd;
      x_ren = (e_c && !c_we) || (e_d && !d_we);
      x_wen = (e_c && c_we) || (e_d && d_we);
      x_rt  = e_c ? c_rtype : (e_d ? d_rtype : 3'd0);
      x_wt  = e_c ? c_wtype : (e_d ? d_wtype : 2'd0);
      x_a   = e_c ? c_addr : (e_d ? d_addr : '0);
      x_wd  = e_c ? c_wdata : (e_d ? d_wdata : '0);
      chk("m_c_gnt", 64'(c_gnt), 64'(e_c));
      chk("m_d_gnt", 64'(d_gnt), 64'(e_d));
      chk("m_ren", 64'(ram_ren), 64'(x_ren));
      chk("m_wen", 64'(ram_wen), 64'(x_wen));
      chk("m_rtype", 64'(ram_rtype), 64'(x_rt));
      chk("m_wtype", 64'(ram_wtype), 64'(x_wt));
      chk("m_addr", ram_addr, x_a);
      chk("m_wdata", ram_wdata, x_wd);
      chk("m_c_rv", 64'(c_rvalid), 64'(m_rv_c));
      chk("m_d_rv", 64'(d_rvalid), 64'(m_rv_d));
      if (m_rv_c || m_rv_d)
         chk("m_rdata", rdata, m_rd_addr ^ PAT);
   end

   // ---------------- directed ----------------
   task automatic idle_in();
      c_req = 0; c_we = 0; c_rtype = 0; c_wtype = 0;
      c_addr = 0; c_wdata = 0;
      d_req = 0; d_we = 0; d_rtype = 0; d_wtype = 0;
      d_addr = 0; d_wdata = 0; d_lock = 0;
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle_in();
      nxt();
      rst_n = 0;
      nxt();
      rst_n = 1;
   endtask

   initial begin
      logic [7:0] pc;
      rst_n = 0;
      idle_in();
      nxt();
      // reset state with both requesting
      c_req = 1; d_req = 1; c_addr = 64'h10; d_addr = 64'h20;
      #1;
      chk("rst_c_gnt", 64'(c_gnt), 64'd0);
      chk("rst_d_gnt", 64'(d_gnt), 64'd0);
      chk("rst_ren", 64'(ram_ren), 64'd0);
      chk("rst_addr", ram_addr, 64'd0);
      chk("rst_c_rv", 64'(c_rvalid), 64'd0);

      // core read alone
      do_reset();
      c_req = 1; c_addr = 64'h100; c_rtype = 3'd2;
      #1;
      chk("t1_c_gnt", 64'(c_gnt), 64'd1);
      chk("t1_ren", 64'(ram_ren), 64'd1);
      chk("t1_addr", ram_addr, 64'h100);
      chk("t1_rtype", 64'(ram_rtype), 64'd2);
      chk("t1_d_gnt", 64'(d_gnt), 64'd0);
      nxt();
      c_req = 0;
      #1;
      chk("t1_c_rv", 64'(c_rvalid), 64'd1);
      chk("t1_rdata", rdata, 64'hA5A5_A5A5_A5A5_A4A5);
      chk("t1_d_rv", 64'(d_rvalid), 64'd0);

      // alternating C, D, C, D
      do_reset();
      c_req = 1; d_req = 1; c_addr = 64'h200; d_addr = 64'h300;
      pc = 8'b0000_0101;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("t2_c_gnt", 64'(c_gnt), 64'(pc[i]));
         chk("t2_d_gnt", 64'(d_gnt), 64'(!pc[i]));
         if (i > 0)
            chk("t2_c_rv", 64'(c_rvalid), 64'(pc[i-1]));
         nxt();
      end

      // full lock burst: C, D x4, C, D
      do_reset();
      c_req = 1; d_req = 1; d_lock = 1;
      c_addr = 64'h400; d_addr = 64'h500;
      pc = 8'b0010_0001;
      for (int i = 0; i < 7; i++) begin
         #1;
         chk("t3_c_gnt", 64'(c_gnt), 64'(pc[i]));
         chk("t3_d_gnt", 64'(d_gnt), 64'(!pc[i]));
         nxt();
      end

      // early release on beat 2: C, D, D, C
      do_reset();
      c_req = 1; d_req = 1; d_lock = 1;
      pc = 8'b0000_1001;
      for (int i = 0; i < 4; i++) begin
         if (i == 2) d_lock = 0;
         #1;
         chk("t4_c_gnt", 64'(c_gnt), 64'(pc[i]));
         chk("t4_d_gnt", 64'(d_gnt), 64'(!pc[i]));
         nxt();
      end

      // DMA write
      do_reset();
      d_req = 1; d_we = 1; d_addr = 64'h40;
      d_wdata = 64'hDEAD; d_wtype = 2'd3;
      #1;
      chk("t5_d_gnt", 64'(d_gnt), 64'd1);
      chk("t5_wen", 64'(ram_wen), 64'd1);
      chk("t5_ren", 64'(ram_ren), 64'd0);
      chk("t5_addr", ram_addr, 64'h40);
      chk("t5_wdata", ram_wdata, 64'hDEAD);
      chk("t5_wtype", 64'(ram_wtype), 64'd3);
      nxt();
      d_req = 0; d_we = 0;
      #1;
      chk("t5_wen_off", 64'(ram_wen), 64'd0);
      chk("t5_d_rv", 64'(d_rvalid), 64'd0);

      // async reset during a locked burst with a read in flight
      do_reset();
      c_req = 1; d_req = 1; d_lock = 1;
      c_addr = 64'h600; d_addr = 64'h700;
      #1;
      chk("t6_c0", 64'(c_gnt), 64'd1);
      nxt();
      #1;
      chk("t6_d1", 64'(d_gnt), 64'd1);
      nxt();
      #1;
      chk("t6_d_rv", 64'(d_rvalid), 64'd1);
      chk("t6_lock_c", 64'(c_gnt), 64'd0);
      #1;
      rst_n = 0;
      #1;
      chk("t6_r_d_rv", 64'(d_rvalid), 64'd0);
      chk("t6_r_d_gnt", 64'(d_gnt), 64'd0);
      chk("t6_r_c_gnt", 64'(c_gnt), 64'd0);
      chk("t6_r_ren", 64'(ram_ren), 64'd0);
      d_lock = 0;
      @(posedge clk);
      #1;
      rst_n = 1;
      #1;
      chk("t6_c_first", 64'(c_gnt), 64'd1);
      chk("t6_d_wait", 64'(d_gnt), 64'd0);
      nxt();
      #1;
      chk("t6_no_stale", 64'(d_rvalid), 64'd0);
      chk("t6_c_rv", 64'(c_rvalid), 64'd1);
      chk("t6_d_next", 64'(d_gnt), 64'd1);
      idle_in();
      nxt();
      nxt();
      nxt();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester arbiter that shares the single data port of the SoC RAM between the core load/store unit (port C) and a DMA/loader master (port D). It sits between `core` and `ram_top` inside `soc_top`. It resolves conflicts round-robin, supports a bounded DMA lock (burst) mode, and returns read data one cycle after issue, tagged to the requester that issued it.

## Interface
Parameters:
- `ADDR_W`, 64: address width (`OPERAND_WIDTH`).
- `DATA_W`, 64: data width (`OPERAND_WIDTH`).
- `BURST_MAX`, 4: maximum consecutive granted DMA beats under lock (2..15).

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `c_req`  in  1: core access request, held until granted.
- `c_we`  in  1: 1 = write, 0 = read.
- `c_rtype`  in  3: load type, passed to RAM.
- `c_wtype`  in  2: store type, passed to RAM.
- `c_addr`  in  ADDR_W: byte address.
- `c_wdata`  in  DATA_W: store data.
- `c_gnt`  out  1: core beat accepted this cycle. Core stalls while `c_req && !c_gnt`.
- `c_rvalid`  out  1: `rdata` holds core read data.
- `d_req`, `d_we`, `d_rtype`, `d_wtype`, `d_addr`, `d_wdata`: DMA equivalents of the core signals.
- `d_lock`  in  1: DMA requests to keep ownership for following beats.
- `d_gnt`  out  1, `d_rvalid`  out  1: DMA equivalents of the core outputs.
- `rdata`  out  DATA_W: shared read-return bus, equal to `ram_rdata`.
- `ram_ren`, `ram_wen`  out  1: RAM strobes.
- `ram_rtype`  out  3, `ram_wtype`  out  2, `ram_addr`  out  ADDR_W, `ram_wdata`  out  DATA_W: RAM command.
- `ram_rdata`  in  DATA_W: RAM read data, valid one cycle after `ram_ren`.

## Operation
- Registered state:
  - `st` ∈ {RR, DLOCK}.
  - `last`: 0 = core, 1 = DMA.
  - `cnt`: 4-bit granted-beat counter.
  - `rv_c`, `rv_d`: registered read-valid flags.
- Grant logic is combinational from requests and registered state. At most one grant is asserted per cycle.
- RR state:
  - Only one requester active: grant it.
  - Both active: grant the one that is not `last`.
  - Any grant updates `last`.
  - DMA granted with `d_lock=1`: go to DLOCK, `cnt<=1`.
- DLOCK state:
  - Core is never granted.
  - DMA is granted whenever `d_req=1`, and `cnt` increments on each granted beat.
  - Exit to RR at the clock edge when either:
    - `d_lock=0` is sampled (that cycle's beat is still granted if `d_req=1`), or
    - a granted beat makes `cnt` reach `BURST_MAX`.
  - On exit, `last<=1`, so a waiting core wins the next contention.
  - DLOCK with `d_req=0`: DMA holds the bus idle and `cnt` is unchanged. This is bounded only by `d_lock`, and deasserting `d_lock` releases immediately.
- RAM command: the granted requester's fields are muxed onto `ram_*`.
  - `ram_ren = gnt & !we`, `ram_wen = gnt & we`.
  - With no grant, `ram_ren=ram_wen=0` and the address/data/type outputs are 0.
- Read return:
  - `rv_c <= c_gnt & !c_we`, `rv_d <= d_gnt & !d_we`.
  - `c_rvalid=rv_c`, `d_rvalid=rv_d`, `rdata=ram_rdata`.
- Writes complete in the granted cycle and produce no response.

## Timing
- Grant latency is 0 cycles when uncontended: `c_req` rises and `c_gnt` is high in the same cycle.
- Read data arrives 1 cycle after grant.
- Back-to-back grants to the same requester are allowed every cycle in both states.
- Worst-case core wait while DMA is locked: `BURST_MAX` cycles plus the unbounded idle hold (DMA responsibility).
- Reset values:
  - `st=RR`, `last=1` (core wins the first contention), `cnt=0`, `rv_c=rv_d=0`.
  - All outputs are 0 except `rdata`, which follows `ram_rdata`.
- Reset mid-burst or with a read in flight: state returns to RR and the pending rvalid is dropped. No data is returned after reset release.
- Simultaneous `d_lock` deassert and `cnt` reaching `BURST_MAX`: a single exit to RR.
- Requests must stay stable until granted. A withdrawn request is simply not granted, with no error.

## Test plan
- Reset then core read only: `c_req=1`, `c_we=0`, `c_addr=0x100` → `c_gnt=1` and `ram_ren=1`, `ram_addr=0x100` in the same cycle. Next cycle `c_rvalid=1` and `rdata=ram_rdata`. `d_*` outputs stay 0.
- Both requesting continuously, no lock, reads → grants alternate C, D, C, D starting with C after reset. `rvalid` follows each grant by 1 cycle on the matching port.
- DMA lock burst, `BURST_MAX=4`, `d_lock=1` held, core also requesting → D granted 4 consecutive cycles, then C granted, then D.
- DMA lock released early: `d_lock` drops on beat 2 → beat 2 is granted, and core is granted the next cycle.
- DMA write `d_addr=0x40`, `d_wdata=0xDEAD` → `ram_wen=1` with matching fields for one cycle. No `d_rvalid`.
- `rst_n` pulsed low asynchronously during DLOCK with a read in flight → all outputs 0 immediately. After release the next contention is granted to core, and no stale rvalid appears.
